dcache_wb: RTL and testbench
============================

DCACHE_WB -- requirements
Module: dcache_wb

Interface
REQ-001 Parameter DATA_BITS, default 32, word width of a store from the store buffer.
REQ-002 Parameter ADDRESS_BITS, default 32, byte address width.
REQ-003 Parameter LINE_BITS, default 128, cache line and memory beat width (4 words).
REQ-004 Parameter SETS, default 4, direct-mapped set count; SET_IDX_BITS, default 2, equals log2(SETS).
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 wMemReq  input  1  store buffer head valid; drain request.
REQ-008 wAddrMem  input  ADDRESS_BITS  store byte address.
REQ-009 wDataMem  input  DATA_BITS  store word.
REQ-010 wMemAck  output  1  store accepted and written; store buffer retires its head at the same posedge.
REQ-011 memReq  output  1  memory transaction request.
REQ-012 memWrite  output  1  1 = line write-back, 0 = line fill; valid while memReq=1.
REQ-013 memAddr  output  ADDRESS_BITS  line-aligned address, low log2(LINE_BITS/8) bits zero.
REQ-014 memWData  output  LINE_BITS  victim line for write-back.
REQ-015 memRData  input  LINE_BITS  fill data; sampled when memAck=1 and memWrite=0.
REQ-016 memAck  input  1  memory completion; ignored unless memReq=1.

Function
REQ-017 Address split (default parameters): byte offset [1:0] ignored; word offset [3:2]; index [5:4]; tag [31:6].
REQ-018 Per-set storage: valid bit, dirty bit, tag, LINE_BITS data.
REQ-019 Hit: wMemReq=1, valid[index]=1, tag[index]=address tag.
REQ-020 FSM states: IDLE, EVICT, FILL, WRITE; reset state IDLE.
REQ-021 IDLE and hit: wMemAck=1 combinationally in the same cycle; the selected word is written and dirty set at that posedge; the FSM stays in IDLE.
REQ-022 IDLE, miss, victim valid and dirty: wMemAck=0; at the next posedge, latch the miss address and go to EVICT.
REQ-023 IDLE, miss, victim clean or invalid: wMemAck=0; at the next posedge, latch the miss address and go to FILL.
REQ-024 EVICT: memReq=1, memWrite=1, memAddr={victim tag, index, 0}, memWData=victim line; on memAck, clear dirty and go to FILL.
REQ-025 FILL: memReq=1, memWrite=0, memAddr=latched line address; on memAck, load memRData, set valid, write tag, clear dirty, and go to WRITE.
REQ-026 WRITE: if wMemReq=1 and wAddrMem matches the latched address, assert wMemAck, write the word, set dirty, and go to IDLE; otherwise go to IDLE with no write, and the next request re-looks-up.
REQ-027 wMemAck=0 in EVICT and FILL; memReq=0 in IDLE and WRITE.
REQ-028 memReq, memWrite and memAddr hold stable from the state's entry until the cycle in which memAck=1.
REQ-029 wMemReq deasserting during EVICT or FILL does not abort the transaction; the line fill completes.
REQ-030 Back-to-back hits: one store per cycle, no bubbles.
REQ-031 Miss latency: clean miss gives wMemAck 2 cycles plus memory latency after the request; dirty miss adds the write-back time.
REQ-032 Index wrap: sets are independent; a conflicting tag always evicts, with no replacement choice.

Reset
REQ-033 rst=1 at posedge: state IDLE, all valid and dirty bits 0; wMemAck=0, memReq=0 and memWrite=0 from the following cycle; line data and tags are unspecified.
REQ-034 rst mid-EVICT or mid-FILL aborts the transaction; memAck arriving after reset is ignored; rst overrides every other input.

Verification
REQ-035 Reset, then store 0x100/0xAAAA5555 (cold miss) -> FILL with memAddr=0x100, memWrite=0; memAck with line 0 -> WRITE; wMemAck=1 one cycle later; word 0 = 0xAAAA5555, dirty=1.
REQ-036 Stores to 0x104, 0x108, 0x10C on consecutive cycles after REQ-035 -> wMemAck=1 in each request cycle, memReq stays 0.
REQ-037 Store to 0x140 (same index, different tag) after REQ-036 -> EVICT with memAddr=0x100, memWData={0x10C,0x108,0x104,0xAAAA5555 words}, then FILL at 0x140, then ack.
REQ-038 Clean conflict miss -> FILL directly; no memWrite=1 cycle observed.
REQ-039 Hold memAck=0 for 5 cycles during FILL -> memReq, memWrite and memAddr stable; wMemAck=0 throughout.
REQ-040 rst asserted during FILL, then memAck pulse -> no state change, all valid bits 0, and the next store to the same address misses.

Source files
------------

// File: rtl/dcache_wb.sv
// Direct-mapped write-back data cache draining a store buffer one word at a time.
// Misses write back a dirty victim, fill the line from memory, then perform the pending store.
module dcache_wb #(
    parameter int DATA_BITS    = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int LINE_BITS    = 128,
    parameter int SETS         = 4,
    parameter int SET_IDX_BITS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wMemReq,
    input  logic [ADDRESS_BITS-1:0] wAddrMem,
    input  logic [DATA_BITS-1:0]    wDataMem,
    output logic                    wMemAck,
    output logic                    memReq,
    output logic                    memWrite,
    output logic [ADDRESS_BITS-1:0] memAddr,
    output logic [LINE_BITS-1:0]    memWData,
    input  logic [LINE_BITS-1:0]    memRData,
    input  logic                    memAck
);

    localparam int LINE_BYTE_BITS = $clog2(LINE_BITS / 8);
    localparam int WORD_BYTE_BITS = $clog2(DATA_BITS / 8);
    localparam int WORD_SEL_BITS  = $clog2(LINE_BITS / DATA_BITS);
    localparam int TAG_BITS       = ADDRESS_BITS - SET_IDX_BITS - LINE_BYTE_BITS;

    typedef enum logic [1:0] {IDLE, EVICT, FILL, WRITE} state_t;

    state_t                    state_q, state_d;
    logic [ADDRESS_BITS-1:0]   miss_addr_q, miss_addr_d;

    logic [SETS-1:0]           valid_vec;
    logic [SETS-1:0]           dirty_vec;
    logic [TAG_BITS-1:0]       tag_vec  [SETS];
    logic [LINE_BITS-1:0]      line_vec [SETS];

    logic [TAG_BITS-1:0]       req_tag;
    logic [SET_IDX_BITS-1:0]   req_idx;
    logic [WORD_SEL_BITS-1:0]  req_word;
    logic [TAG_BITS-1:0]       miss_tag;
    logic [SET_IDX_BITS-1:0]   miss_idx;
    logic                      hit;
    logic                      write_match;
    logic                      fill_done;
    logic                      evict_done;
    logic                      unused_byte_offset;

    assign req_tag   = wAddrMem[ADDRESS_BITS-1 -: TAG_BITS];
    assign req_idx   = wAddrMem[LINE_BYTE_BITS +: SET_IDX_BITS];
    assign req_word  = wAddrMem[WORD_BYTE_BITS +: WORD_SEL_BITS];
    assign miss_tag  = miss_addr_q[ADDRESS_BITS-1 -: TAG_BITS];
    assign miss_idx  = miss_addr_q[LINE_BYTE_BITS +: SET_IDX_BITS];

    // Stores are word granular; the byte offset carries no information.
    assign unused_byte_offset = ^wAddrMem[WORD_BYTE_BITS-1:0];

    assign hit = wMemReq && valid_vec[req_idx] && (tag_vec[req_idx] == req_tag);
    assign write_match = wMemReq &&
        (wAddrMem[ADDRESS_BITS-1:LINE_BYTE_BITS] == miss_addr_q[ADDRESS_BITS-1:LINE_BYTE_BITS]);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        case (state_q)
            IDLE: begin
                if (wMemReq && !hit) begin
                    miss_addr_d = {wAddrMem[ADDRESS_BITS-1:LINE_BYTE_BITS], {LINE_BYTE_BITS{1'b0}}};
                    state_d     = (valid_vec[req_idx] && dirty_vec[req_idx]) ? EVICT : FILL;
                end
            end
            EVICT: begin
                if (memAck) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (memAck) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic; reset silences every handshake in the same cycle.
    always_comb begin
        wMemAck    = 1'b0;
        memReq     = 1'b0;
        memWrite   = 1'b0;
        memAddr    = miss_addr_q;
        memWData   = line_vec[miss_idx];
        fill_done  = 1'b0;
        evict_done = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    wMemAck = hit;
                end
                EVICT: begin
                    memReq     = 1'b1;
                    memWrite   = 1'b1;
                    memAddr    = {tag_vec[miss_idx], miss_idx, {LINE_BYTE_BITS{1'b0}}};
                    evict_done = memAck;
                end
                FILL: begin
                    memReq    = 1'b1;
                    fill_done = memAck;
                end
                WRITE: begin
                    wMemAck = write_match;
                end
                default: begin
                    wMemAck = 1'b0;
                end
            endcase
        end
    end

    // Per-set storage. The store always targets the request's own set, both on a
    // hit and in WRITE (where the request index equals the latched miss index).
    for (genvar gi = 0; gi < SETS; gi++) begin : g_set
        logic                 valid_q, valid_d;
        logic                 dirty_q, dirty_d;
        logic [TAG_BITS-1:0]  tag_q, tag_d;
        logic [LINE_BITS-1:0] line_q, line_d;
        logic                 sel_miss;
        logic                 sel_req;

        assign sel_miss = (miss_idx == SET_IDX_BITS'(gi));
        assign sel_req  = (req_idx == SET_IDX_BITS'(gi));

        always_comb begin
            valid_d = valid_q;
            dirty_d = dirty_q;
            tag_d   = tag_q;
            line_d  = line_q;
            if (evict_done && sel_miss) begin
                dirty_d = 1'b0;
            end
            if (fill_done && sel_miss) begin
                valid_d = 1'b1;
                dirty_d = 1'b0;
                tag_d   = miss_tag;
                line_d  = memRData;
            end
            if (wMemAck && sel_req) begin
                dirty_d = 1'b1;
                line_d[req_word*DATA_BITS +: DATA_BITS] = wDataMem;
            end
        end

        always_ff @(posedge clk) begin
            tag_q  <= tag_d;
            line_q <= line_d;
            if (rst) begin
                valid_q <= 1'b0;
                dirty_q <= 1'b0;
            end else begin
                valid_q <= valid_d;
                dirty_q <= dirty_d;
            end
        end

        assign valid_vec[gi] = valid_q;
        assign dirty_vec[gi] = dirty_q;
        assign tag_vec[gi]   = tag_q;
        assign line_vec[gi]  = line_q;
    end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: a memory model answers line requests, a scoreboard
// holds the expected memory transactions and store-ack latencies.
module tb_dcache_wb;

    logic         clk = 1'b0;
    logic         rst;
    logic         wMemReq;
    logic [31:0]  wAddrMem;
    logic [31:0]  wDataMem;
    logic         wMemAck;
    logic         memReq;
    logic         memWrite;
    logic [31:0]  memAddr;
    logic [127:0] memWData;
    logic [127:0] memRData;
    logic         memAck;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
    } mem_op_t;

    mem_op_t      mem_q[$];
    int           ack_q[$];
    logic [127:0] backing_mem [logic [31:0]];
    logic [127:0] arch_mem    [logic [31:0]];

    dcache_wb dut (
        .clk      (clk),
        .rst      (rst),
        .wMemReq  (wMemReq),
        .wAddrMem (wAddrMem),
        .wDataMem (wDataMem),
        .wMemAck  (wMemAck),
        .memReq   (memReq),
        .memWrite (memWrite),
        .memAddr  (memAddr),
        .memWData (memWData),
        .memRData (memRData),
        .memAck   (memAck)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] backing_line(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:4], 4'h0};
        return backing_mem.exists(k) ? backing_mem[k] : 128'h0;
    endfunction

    function automatic logic [127:0] arch_line(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:4], 4'h0};
        return arch_mem.exists(k) ? arch_mem[k] : 128'h0;
    endfunction

    // Cached contents are lost on reset; the architectural view falls back to memory.
    task automatic resync_arch();
        arch_mem.delete();
        foreach (backing_mem[k]) arch_mem[k] = backing_mem[k];
    endtask

    // Drives one store (entered and left #1 after a posedge), serves memory
    // requests after `lat` wait cycles, checks them against the scoreboard.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input int lat, input int exp_cyc);
        mem_op_t      cur;
        logic [127:0] line;
        bit           busy;
        bit           done;
        int           waitc;
        int           cyc;
        int           exp_lat;
        busy = 0;
        done = 0;
        waitc = 0;
        cyc = 0;
        cur = '0;
        ack_q.push_back(exp_cyc);
        wMemReq  = 1'b1;
        wAddrMem = a;
        wDataMem = d;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (memReq) begin
                if (!busy) begin
                    if (mem_q.size() == 0) begin
                        check("unexpected_memreq", 1'b1, 1'b0);
                        cur = '{wr: memWrite, addr: memAddr};
                    end else begin
                        cur = mem_q.pop_front();
                    end
                    busy  = 1;
                    waitc = 0;
                    check("mem_write", memWrite, cur.wr);
                    check("mem_addr", memAddr, cur.addr);
                    if (cur.wr) check("wb_data", memWData, arch_line(cur.addr));
                end else begin
                    check("hold_write", memWrite, cur.wr);
                    check("hold_addr", memAddr, cur.addr);
                end
                check("no_ack_during_mem", wMemAck, 1'b0);
                if (waitc >= lat) begin
                    memAck = 1'b1;
                    if (cur.wr) backing_mem[cur.addr] = memWData;
                    else memRData = backing_line(cur.addr);
                    busy = 0;
                end
                waitc++;
            end
            if (wMemAck) begin
                exp_lat = ack_q.pop_front();
                check("ack_latency", cyc, exp_lat);
                check("ack_memreq_low", memReq, 1'b0);
                line = arch_line(a);
                line[a[3:2]*32 +: 32] = d;
                arch_mem[{a[31:4], 4'h0}] = line;
                done = 1;
                $display("store addr=%08h data=%08h acked after %0d cycle(s)", a, d, cyc);
            end
            @(posedge clk);
            #1;
            memAck = 1'b0;
        end
        if (!done) begin
            check("store_timeout", 1'b0, 1'b1);
            void'(ack_q.pop_front());
        end
    endtask

    initial begin
        rst      = 1'b1;
        wMemReq  = 1'b0;
        wAddrMem = '0;
        wDataMem = '0;
        memRData = '0;
        memAck   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_wmemack", wMemAck, 1'b0);
        check("reset_memreq", memReq, 1'b0);
        check("reset_memwrite", memWrite, 1'b0);
        @(posedge clk);
        #1;

        // Cold miss, then back-to-back hits on the same line.
        mem_q.push_back('{wr: 1'b0, addr: 32'h100});
        store(32'h100, 32'hAAAA5555, 0, 3);
        store(32'h104, 32'h1111_0104, 0, 1);
        store(32'h108, 32'h2222_0108, 0, 1);
        store(32'h10C, 32'h3333_010C, 0, 1);

        // Dirty conflict: write-back of 0x100 then fill of 0x140.
        mem_q.push_back('{wr: 1'b1, addr: 32'h100});
        mem_q.push_back('{wr: 1'b0, addr: 32'h140});
        store(32'h140, 32'h4444_0140, 1, 6);
        check("wb_line_0x100", backing_line(32'h100),
              128'h3333_010C_2222_0108_1111_0104_AAAA5555);

        // Another set is independent of set 0.
        mem_q.push_back('{wr: 1'b0, addr: 32'h110});
        store(32'h110, 32'h5555_0110, 0, 3);
        store(32'h144, 32'h6666_0144, 0, 1);
        store(32'h114, 32'h7777_0114, 0, 1);

        // Request withdrawn during FILL: fill still completes, WRITE does nothing.
        wMemReq  = 1'b1;
        wAddrMem = 32'h120;
        wDataMem = 32'h5A5A_0120;
        @(negedge clk);
        check("drop_idle_ack", wMemAck, 1'b0);
        check("drop_idle_req", memReq, 1'b0);
        @(posedge clk);
        #1 wMemReq = 1'b0;
        @(negedge clk);
        check("drop_fill_req", memReq, 1'b1);
        check("drop_fill_write", memWrite, 1'b0);
        check("drop_fill_addr", memAddr, 32'h120);
        memAck   = 1'b1;
        memRData = backing_line(32'h120);
        @(posedge clk);
        #1 memAck = 1'b0;
        @(negedge clk);
        check("drop_write_ack", wMemAck, 1'b0);
        check("drop_write_req", memReq, 1'b0);
        @(posedge clk);
        #1;

        // Clean conflict goes straight to FILL; memAck held off 5 cycles.
        mem_q.push_back('{wr: 1'b0, addr: 32'h160});
        store(32'h160, 32'h8888_0160, 5, 8);
        mem_q.push_back('{wr: 1'b1, addr: 32'h160});
        mem_q.push_back('{wr: 1'b0, addr: 32'h120});
        store(32'h120, 32'h9999_0120, 0, 4);

        // Reset mid-FILL, then a stray memAck.
        wMemReq  = 1'b1;
        wAddrMem = 32'h130;
        wDataMem = 32'hBEEF_0130;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("pre_rst_fill_req", memReq, 1'b1);
        check("pre_rst_fill_addr", memAddr, 32'h130);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        wMemReq  = 1'b0;
        memAck   = 1'b1;
        memRData = {128{1'b1}};
        @(negedge clk);
        check("post_rst_memreq", memReq, 1'b0);
        check("post_rst_memwrite", memWrite, 1'b0);
        check("post_rst_wmemack", wMemAck, 1'b0);
        @(posedge clk);
        #1 memAck = 1'b0;
        @(negedge clk);
        check("post_ack_memreq", memReq, 1'b0);
        @(posedge clk);
        #1;
        resync_arch();
        $display("reset applied during FILL");

        // All lines invalid after reset: previously cached addresses miss again.
        mem_q.push_back('{wr: 1'b0, addr: 32'h130});
        store(32'h130, 32'hBEEF_0130, 0, 3);
        mem_q.push_back('{wr: 1'b0, addr: 32'h140});
        store(32'h140, 32'hCAFE_0140, 2, 5);
        mem_q.push_back('{wr: 1'b1, addr: 32'h140});
        mem_q.push_back('{wr: 1'b0, addr: 32'h100});
        store(32'h104, 32'hD00D_0104, 0, 4);
        mem_q.push_back('{wr: 1'b1, addr: 32'h100});
        mem_q.push_back('{wr: 1'b0, addr: 32'h180});
        store(32'h180, 32'hF00D_0180, 0, 4);
        check("wb_line_0x100_after_rst", backing_line(32'h100),
              128'h3333_010C_2222_0108_D00D_0104_AAAA5555);
        check("scoreboard_drained", mem_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
